// File: rtl/vga_scan_gen_pkg.sv
// Shared VGA timing constants and the pixel-coordinate type used by the scan generator
// and by every downstream pixel-colour stage.
package vga_pkg;

   typedef logic [10:0] pix_coord_t;

   localparam int unsigned CoordMax  = 2047;

   // Default 640x480@60 Hz timing with a 25 MHz pixel rate from a 50 MHz clock.
   localparam int unsigned ClkDivDef = 2;
   localparam int unsigned HVisible  = 640;
   localparam int unsigned HFp       = 16;
   localparam int unsigned HSync     = 96;
   localparam int unsigned HBp       = 48;
   localparam int unsigned VVisible  = 480;
   localparam int unsigned VFp       = 10;
   localparam int unsigned VSync     = 2;
   localparam int unsigned VBp       = 33;

   localparam int unsigned HTotal    = HVisible + HFp + HSync + HBp;
   localparam int unsigned VTotal    = VVisible + VFp + VSync + VBp;

   function automatic logic coord_ge(pix_coord_t v, int unsigned lim);
      return 32'(v) >= lim;
   endfunction

   function automatic logic in_window(pix_coord_t v, int unsigned lo, int unsigned len);
      return (32'(v) >= lo) && (32'(v) < lo + len);
   endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster timing bundle driven by the scan generator and consumed by pixel-colour stages.
interface vga_scan_gen_if;
   import vga_pkg::*;

   pix_coord_t col;
   pix_coord_t row;
   logic       HS;
   logic       VS;
   logic       blank;
   logic       pix_en;
   logic       frame_start;

   modport master (output col, row, HS, VS, blank, pix_en, frame_start);
   modport slave  (input  col, row, HS, VS, blank, pix_en, frame_start);

endinterface

// File: rtl/vga_scan_gen_counter.sv
// Up-counter with enable and synchronous clear that wraps to zero after MAX.
// The next-state value is exported so callers can register look-ahead decodes.
module vga_scan_gen_counter
   import vga_pkg::*;
#(
   parameter int unsigned MAX = 1
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       en,
   output pix_coord_t count,
   output pix_coord_t count_next,
   output logic       wrap
);

   pix_coord_t count_q;

   always_comb begin
      wrap       = en && (count_q == pix_coord_t'(MAX));
      count_next = count_q;
      if (wrap) begin
         count_next = '0;
      end else if (en) begin
         count_next = count_q + 11'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_next;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing: pixel-rate divider, column/row scan counters, sync, blank and
// pixel-enable. Sync and blank are decoded from the counters' next state so they stay aligned.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV   = ClkDivDef,
   parameter int unsigned H_VISIBLE = HVisible,
   parameter int unsigned H_FP      = HFp,
   parameter int unsigned H_SYNC    = HSync,
   parameter int unsigned H_BP      = HBp,
   parameter int unsigned V_VISIBLE = VVisible,
   parameter int unsigned V_FP      = VFp,
   parameter int unsigned V_SYNC    = VSync,
   parameter int unsigned V_BP      = VBp
) (
   input  logic           clock,
   input  logic           reset,
   vga_scan_gen_if.master scan
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > CoordMax) begin : g_h_range
      $fatal(1, "H_TOTAL does not fit the 11-bit column counter");
   end
   if (V_TOTAL > CoordMax) begin : g_v_range
      $fatal(1, "V_TOTAL does not fit the 11-bit row counter");
   end
   if (CLK_DIV < 1) begin : g_div_range
      $fatal(1, "CLK_DIV must be at least 1");
   end

   pix_coord_t div_count, div_next;
   pix_coord_t col_count, col_next;
   pix_coord_t row_count, row_next;
   logic       div_wrap, col_wrap, row_wrap;
   logic       pix_en_q, hs_q, vs_q, blank_q;

   vga_scan_gen_counter #(
      .MAX (CLK_DIV - 1)
   ) u_div (
      .clock      (clock),
      .clear      (reset),
      .en         (1'b1),
      .count      (div_count),
      .count_next (div_next),
      .wrap       (div_wrap)
   );

   // Scan counters step on the edge that closes a pix_en cycle.
   vga_scan_gen_counter #(
      .MAX (H_TOTAL - 1)
   ) u_col (
      .clock      (clock),
      .clear      (reset),
      .en         (pix_en_q),
      .count      (col_count),
      .count_next (col_next),
      .wrap       (col_wrap)
   );

   vga_scan_gen_counter #(
      .MAX (V_TOTAL - 1)
   ) u_row (
      .clock      (clock),
      .clear      (reset),
      .en         (col_wrap),
      .count      (row_count),
      .count_next (row_next),
      .wrap       (row_wrap)
   );

   logic unused_sig;
   assign unused_sig = ^{div_count, div_next, row_wrap};

   always_ff @(posedge clock) begin
      if (reset) begin
         pix_en_q <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         blank_q  <= 1'b0;
      end else begin
         pix_en_q <= div_wrap;
         hs_q     <= !in_window(col_next, H_VISIBLE + H_FP, H_SYNC);
         vs_q     <= !in_window(row_next, V_VISIBLE + V_FP, V_SYNC);
         blank_q  <= coord_ge(col_next, H_VISIBLE) || coord_ge(row_next, V_VISIBLE);
      end
   end

   assign scan.col         = col_count;
   assign scan.row         = row_count;
   assign scan.HS          = hs_q;
   assign scan.VS          = vs_q;
   assign scan.blank       = blank_q;
   assign scan.pix_en      = pix_en_q;
   assign scan.frame_start = pix_en_q && (col_count == '0) && (row_count == '0);

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Generates VGA raster timing for the Tetris display: horizontal/vertical counters, sync pulses, blanking and pixel-enable.
- Sits directly upstream of every pixel-colour stage, including the well-wall, block and score generators.
- Its col/row outputs drive their 11-bit col/row inputs.
- Default timing is 640x480@60 Hz, giving a 25 MHz pixel rate derived from the 50 MHz board clock.

Parameters:
- CLK_DIV, 2, system clocks per pixel (1 = one pixel every clock)
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- col  out  11  current horizontal pixel count, 0..H_TOTAL-1
- row  out  11  current line count, 0..V_TOTAL-1
- HS  out  1  horizontal sync, active low
- VS  out  1  vertical sync, active low
- blank  out  1  high when col>=H_VISIBLE or row>=V_VISIBLE
- pix_en  out  1  one-clock pulse marking the clock on which the current col/row pixel is sampled by the DAC/consumers
- frame_start  out  1  one-clock pulse, high while (col,row)=(0,0) and pix_en=1

Behaviour:
- Derived totals: H_TOTAL = sum of the H_ parameters (800); V_TOTAL = sum of the V_ parameters (525).
- Interface: one clock; reset is synchronous and active-high.
- Divider: div counter runs 0..CLK_DIV-1 and wraps to 0. pix_en is registered and =1 on the clock where div==CLK_DIV-1. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Scan counters advance only on the clock edge that ends a pix_en cycle, so each (col,row) is held for exactly CLK_DIV clocks.
  - col increments. At col==H_TOTAL-1, col goes to 0 and row increments.
  - At col==H_TOTAL-1 and row==V_TOTAL-1, both go to 0.
- Registered outputs: HS, VS and blank are registered and update on the same edge as col/row. All outputs are mutually consistent in every cycle, with zero relative latency.
- Sync windows:
  - HS=0 iff H_VISIBLE+H_FP <= col < H_VISIBLE+H_FP+H_SYNC (656..751).
  - VS=0 iff V_VISIBLE+V_FP <= row < V_VISIBLE+V_FP+V_SYNC (490..491).
  - VS depends on row only, not on col.
- Reset state (asserted on any edge, including mid-frame or mid-line): div=0, col=0, row=0, HS=1, VS=1, blank=0, pix_en=0, frame_start=0. First pix_en occurs CLK_DIV clocks after reset deasserts.
- frame_start: asserted exactly once per frame, coincident with pix_en at (0,0). This includes the first (0,0) after reset.
- Width rule: all counters are 11 bits. Elaboration must fail (assertion) if H_TOTAL or V_TOTAL exceeds 2047, or if CLK_DIV < 1.
- No inputs other than clock/reset. Free-running with no stall; reset is the only way to resynchronise.

Decomposition:
- Package vga_pkg holds:
  - the timing constants (640x480 set) and the derived H_TOTAL/V_TOTAL;
  - typedef pix_coord_t as logic [10:0], shared with the pixel-colour stages.
- One natural sub-module: counter, an up-counter with enable, synchronous clear and wrap at parameter MAX. It is instantiated three times: div, col and row, with row enabled by the col wrap.

Test Plan:
- Reset/divider: hold reset 3 clocks, release, CLK_DIV=2 -> col=0,row=0, HS=1, VS=1, blank=0 during reset; first pix_en exactly 2 clocks after release; pix_en then every 2nd clock.
- Horizontal edges: run to col=639 then 640 -> blank 0 then 1; HS falls when col becomes 656 and rises when col becomes 752; col=799 then (col=0, row+1).
- Vertical edges: run to row=489/490/492 -> VS=1/0/1; blank=1 for all rows 480..524 regardless of col.
- Frame wrap: from (799,524) next pixel -> (0,0) with frame_start=1 for exactly one clock. Count clocks between frame_start pulses = 800*525*2 = 840000.
- Mid-frame reset: assert reset at (col=300,row=200) for 1 clock -> next clock all outputs at reset values, then normal restart, with the first frame_start 2 clocks after release.
- Consumer check: drive well_walls from col/row. Sampling colour on pix_en at (col=100,row=25) -> grey 24'hCCCCCC; at (99,25) -> 24'h0; blank=0 for both.
